busca_instrucao: RTL and testbench

//  Instruction fetch unit that reads the program ROM. Holds the PC and drives the
//  ROM address. Captures each 8-bit instruction word and splits it into

---
 rtl/busca_instrucao.sv | 93 +++++++++
 tb/tb_busca_instrucao.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: holds the PC, reads the program ROM and hands each
// opcode/operand pair to execute over a valid/ready handshake with branch redirects.
module busca_instrucao #(
  parameter logic [7:0] PC_RESET   = 8'h00,
  parameter logic [3:0] OPCODE_MAX = 4'hA
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_endereco,
  input  logic [7:0] rom_instrucao,
  output logic       instr_valida,
  input  logic       instr_pronta,
  output logic [3:0] opcode,
  output logic [3:0] operando,
  output logic [7:0] pc_atual,
  input  logic       desvio_req,
  input  logic [7:0] desvio_alvo,
  input  logic       parar,
  output logic       parado,
  output logic       erro
);

  // state   | meaning
  // BUSCA   | ROM addressed by pc, word captured at the edge
  // ENTREGA | instruction presented, waiting for execute to accept
  // PARADO  | fetching suspended while parar is held
  // ERRO    | illegal opcode seen, locked until reset
  typedef enum logic [1:0] {BUSCA, ENTREGA, PARADO, ERRO} estado_t;

  estado_t    estado, estado_prox;
  logic [7:0] pc, pc_prox;
  logic       captura;

  always_comb begin
    estado_prox = estado;
    pc_prox     = pc;
    captura     = 1'b0;
    case (estado)
      BUSCA: begin
        if (desvio_req) begin
          pc_prox = desvio_alvo;
        end else if (parar) begin
          estado_prox = PARADO;
        end else if (rom_instrucao[7:4] > OPCODE_MAX) begin
          estado_prox = ERRO;
        end else begin
          captura     = 1'b1;
          pc_prox     = pc + 8'd1;
          estado_prox = ENTREGA;
        end
      end
      ENTREGA: begin
        // a redirect flushes the held instruction even if it is being accepted
        if (desvio_req) begin
          pc_prox     = desvio_alvo;
          estado_prox = BUSCA;
        end else if (instr_pronta) begin
          estado_prox = BUSCA;
        end
      end
      PARADO: begin
        if (desvio_req) pc_prox = desvio_alvo;
        if (!parar) estado_prox = BUSCA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= BUSCA;
      pc       <= PC_RESET;
      opcode   <= 4'h0;
      operando <= 4'h0;
      pc_atual <= 8'h00;
      erro     <= 1'b0;
    end else begin
      estado <= estado_prox;
      pc     <= pc_prox;
      if (estado_prox == ERRO) erro <= 1'b1;
      if (captura) begin
        opcode   <= rom_instrucao[7:4];
        operando <= rom_instrucao[3:0];
        pc_atual <= pc;
      end
    end
  end

  assign rom_endereco = pc;
  assign instr_valida = (estado == ENTREGA);
  assign parado       = (estado == PARADO);

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch rules.
module tb_busca_instrucao;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rom_endereco;
  logic [7:0] rom_instrucao;
  logic       instr_valida;
  logic       instr_pronta;
  logic [3:0] opcode;
  logic [3:0] operando;
  logic [7:0] pc_atual;
  logic       desvio_req;
  logic [7:0] desvio_alvo;
  logic       parar;
  logic       parado;
  logic       erro;

  logic [7:0] rom [256];
  assign rom_instrucao = rom[rom_endereco];

  busca_instrucao dut (
    .clk(clk), .rst_n(rst_n),
    .rom_endereco(rom_endereco), .rom_instrucao(rom_instrucao),
    .instr_valida(instr_valida), .instr_pronta(instr_pronta),
    .opcode(opcode), .operando(operando), .pc_atual(pc_atual),
    .desvio_req(desvio_req), .desvio_alvo(desvio_alvo),
    .parar(parar), .parado(parado), .erro(erro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: the fetch unit is either holding an instruction, suspended,
  // locked on an error, or free to fetch the word at m_pc
  logic [7:0] m_pc, m_pca;
  logic [3:0] m_op, m_opd;
  logic       m_held, m_stop, m_err;

  task automatic model_reset();
    m_pc = 8'h00; m_pca = 8'h00; m_op = 4'h0; m_opd = 4'h0;
    m_held = 1'b0; m_stop = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic pr, input logic dv, input logic [7:0] al,
                            input logic pa, input logic [7:0] w);
    if (m_err) begin
    end else if (m_held) begin
      if (dv) begin m_pc = al; m_held = 1'b0; end
      else if (pr) m_held = 1'b0;
    end else if (m_stop) begin
      if (dv) m_pc = al;
      if (!pa) m_stop = 1'b0;
    end else if (dv) begin
      m_pc = al;
    end else if (pa) begin
      m_stop = 1'b1;
    end else if (w[7:4] > 4'd10) begin
      m_err = 1'b1;
    end else begin
      m_op = w[7:4]; m_opd = w[3:0]; m_pca = m_pc;
      m_pc = m_pc + 8'd1; m_held = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valida", instr_valida, m_held);
    chk("parado", parado, m_stop);
    chk("erro", erro, m_err);
    chk("endereco", rom_endereco, m_pc);
    chk("opcode", opcode, m_op);
    chk("operando", operando, m_opd);
    chk("pc_atual", pc_atual, m_pca);
  endtask

  // one clock: check current outputs, drive inputs, let the edge happen
  task automatic cyc(input logic pr, input logic dv, input logic [7:0] al, input logic pa);
    logic [7:0] w;
    check_all();
    instr_pronta = pr; desvio_req = dv; desvio_alvo = al; parar = pa;
    w = rom[m_pc];
    @(posedge clk);
    model_step(pr, dv, al, pa, w);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    instr_pronta = 1'b0; desvio_req = 1'b0; parar = 1'b0;
    #1;
    chk("rst_valida", instr_valida, 1'b0);
    chk("rst_erro", erro, 1'b0);
    chk("rst_endereco", rom_endereco, 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic pa_lvl;
    int   err_age;
    rst_n = 1'b0;
    instr_pronta = 1'b0; desvio_req = 1'b0; desvio_alvo = 8'h00; parar = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h61; rom[8'h01] = 8'h37; rom[8'h02] = 8'h52;
    rom[8'h0B] = 8'h7E; rom[8'h0C] = 8'h11; rom[8'h0E] = 8'h25;
    rom[8'hFF] = 8'h42;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_pc", rom_endereco, 8'h00);
    chk("reset_opcode", opcode, 4'h0);

    // 1: back-to-back fetch with execute always ready
    cyc(1, 0, 8'h00, 0);
    chk("t1_op0", {opcode, operando, pc_atual}, 16'h6100);
    cyc(1, 0, 8'h00, 0);
    chk("t1_gap", instr_valida, 1'b0);
    cyc(1, 0, 8'h00, 0);
    chk("t1_op1", {opcode, operando, pc_atual}, 16'h3701);

    // 2: backpressure keeps the presented instruction frozen
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'h00, 0);
      chk("t2_hold", {instr_valida, opcode, operando, pc_atual, rom_endereco}, {1'b1, 24'h370102});
    end
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    chk("t2_next", pc_atual, 8'h02);
    cyc(1, 0, 8'h00, 0);

    // 3: JMP at 0B redirects to 0E; 0C is never presented
    cyc(1, 1, 8'h0B, 0);
    cyc(1, 0, 8'h00, 0);
    chk("t3_jmp", {opcode, pc_atual}, 12'h70B);
    cyc(1, 0, 8'h00, 0);
    cyc(1, 1, 8'h0E, 0);
    chk("t3_nowrong", instr_valida, 1'b0);
    cyc(1, 0, 8'h00, 0);
    chk("t3_target", pc_atual, 8'h0E);

    // 4: redirect while presenting flushes the held instruction
    cyc(0, 1, 8'h01, 0);
    chk("t4_flush", instr_valida, 1'b0);
    cyc(1, 0, 8'h00, 0);
    chk("t4_from01", {instr_valida, pc_atual}, 9'h101);
    cyc(1, 0, 8'h00, 0);

    // 5: suspend in BUSCA, resume at same pc, then PC wrap from FF
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_parado", {parado, instr_valida, rom_endereco}, {2'b10, 8'h02});
      cyc(0, 0, 8'h00, 1);
    end
    cyc(1, 0, 8'h00, 0);
    chk("t5_resume", {parado, rom_endereco}, 9'h002);
    cyc(1, 1, 8'hFF, 0);
    cyc(1, 0, 8'h00, 0);
    chk("t5_wrap", {pc_atual, rom_endereco}, 16'hFF00);
    cyc(1, 0, 8'h00, 0);

    // 6: illegal opcode locks the unit; reset clears it
    rom[8'h01] = 8'hC0;
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    chk("t6_erro", {erro, rom_endereco}, 9'h101);
    cyc(1, 1, 8'h33, 0);
    cyc(1, 0, 8'h00, 1);
    chk("t6_locked", {erro, instr_valida, parado, rom_endereco}, 11'h401);
    do_reset();
    chk("t6_cleared", {erro, rom_endereco}, 9'h000);

    // random traffic
    for (int i = 0; i < 256; i++)
      rom[i] = {(($urandom_range(0, 39) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10))),
                4'($urandom)};
    pa_lvl = 1'b0;
    err_age = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) pa_lvl = ~pa_lvl;
      err_age = m_err ? err_age + 1 : 0;
      if ($urandom_range(0, 299) == 0 || err_age > 12) begin
        do_reset();
        err_age = 0;
      end else begin
        cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 8'($urandom), pa_lvl);
      end
    end
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
